// File: rtl/kernel3_fifo_srl_ctrl.sv
// kernel3_fifo_srl_ctrl
//   Occupancy and handshake controller for the kernel3 shift-register FIFO.
//   The storage it drives is an SRL array. When the storage sees we = 1, every
//   entry moves up one slot and new data enters slot 0. The storage output
//   dout is read from slot addr. This block holds no data of its own.
//
// Ports
//   clk          in   clock; all state updates on its rising edge
//   reset        in   synchronous, active-high reset
//   if_write_ce  in   producer clock enable
//   if_write     in   producer write request
//   if_full_n    out  1 = space available (registered)
//   if_read_ce   in   consumer clock enable
//   if_read      in   consumer read request
//   if_empty_n   out  1 = data valid at storage dout (registered)
//   shift_we     out  storage shift/write enable (combinational, equals push)
//   shift_addr   out  storage read slot of the oldest entry (registered)
//   usedw        out  occupancy, 0..DEPTH (registered)
//   err_flag     out  sticky overflow/underflow-attempt flag
//
// Build option
//   KERNEL3_FIFO_SRL_CTRL_ERR_EN: when defined, err_flag records any write
//   attempt while full and any read attempt while empty. When undefined,
//   err_flag is tied to 0.

module kernel3_fifo_srl_ctrl #(
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic                  if_empty_n,
    output logic                  shift_we,
    output logic [ADDR_WIDTH-1:0] shift_addr,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  err_flag
);

    localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StEmpty,
        StPartial,
        StFull
    } state_e;

    state_e state;

    logic push;
    logic pop;

    // The full/empty flags gate the requests. Writes while full and reads
    // while empty are therefore dropped here.
    assign push     = if_write & if_write_ce & if_full_n;
    assign pop      = if_read & if_read_ce & if_empty_n;
    assign shift_we = push;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StEmpty;
            usedw      <= '0;
            shift_addr <= '0;
            if_full_n  <= 1'b1;
            if_empty_n <= 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    usedw      <= usedw + 1'b1;
                    if_empty_n <= 1'b1;
                    // Leaving empty, the single entry sits in slot 0.
                    if (state != StEmpty) begin
                        shift_addr <= shift_addr + ADDR_WIDTH'(1);
                    end
                    if (usedw + 1'b1 == DepthW) begin
                        state     <= StFull;
                        if_full_n <= 1'b0;
                    end else begin
                        state <= StPartial;
                    end
                end
                2'b01: begin
                    usedw     <= usedw - 1'b1;
                    if_full_n <= 1'b1;
                    if (usedw == (ADDR_WIDTH + 1)'(1)) begin
                        state      <= StEmpty;
                        if_empty_n <= 1'b0;
                        shift_addr <= '0;
                    end else begin
                        state      <= StPartial;
                        shift_addr <= shift_addr - ADDR_WIDTH'(1);
                    end
                end
                // When push and pop happen together, the shift moves the oldest
                // entry up one slot while the pop retires it. Nothing changes here.
                default: begin
                end
            endcase
        end
    end

`ifdef KERNEL3_FIFO_SRL_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag <= 1'b0;
        end else if ((if_write & if_write_ce & ~if_full_n) |
                     (if_read & if_read_ce & ~if_empty_n)) begin
            err_flag <= 1'b1;
        end
    end
`else
    assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_kernel3_fifo_srl_ctrl.sv
// Directed, table-driven bench for kernel3_fifo_srl_ctrl (DEPTH=2, ADDR_WIDTH=1).
// A small SRL storage model is attached so that data ordering can be observed.
module tb_kernel3_fifo_srl_ctrl;

`ifdef KERNEL3_FIFO_SRL_CTRL_ERR_EN
    localparam logic E = 1'b1;
`else
    localparam logic E = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       if_write_ce, if_write, if_full_n;
    logic       if_read_ce, if_read, if_empty_n;
    logic       shift_we;
    logic [0:0] shift_addr;
    logic [1:0] usedw;
    logic       err_flag;

    always #5 clk = ~clk;

    kernel3_fifo_srl_ctrl #(
        .ADDR_WIDTH(1),
        .DEPTH     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_write_ce(if_write_ce),
        .if_write   (if_write),
        .if_full_n  (if_full_n),
        .if_read_ce (if_read_ce),
        .if_read    (if_read),
        .if_empty_n (if_empty_n),
        .shift_we   (shift_we),
        .shift_addr (shift_addr),
        .usedw      (usedw),
        .err_flag   (err_flag)
    );

    // SRL storage model
    logic [7:0] din;
    logic [7:0] mem [0:1];
    logic [7:0] dout;
    always @(posedge clk) begin
        if (shift_we) begin
            mem[1] <= mem[0];
            mem[0] <= din;
        end
    end
    assign dout = mem[shift_addr];

    typedef struct {
        logic       rst, wce, w, rce, r;
        logic       we, fn, en;
        logic [1:0] used;
        logic       addr, err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic rst, wce, w, rce, r, we, fn, en,
                       input logic [1:0] used, input logic addr, err);
        vec_t v;
        v.rst = rst; v.wce = wce; v.w = w; v.rce = rce; v.r = r;
        v.we = we; v.fn = fn; v.en = en; v.used = used; v.addr = addr; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, wce, w, rce, r);
        reset = rst; if_write_ce = wce; if_write = w; if_read_ce = rce; if_read = r;
    endtask

    // Apply inputs, check shift_we before the edge, then let the edge happen.
    task automatic step(input logic rst, wce, w, rce, r, input logic exp_we,
                        input int idx);
        drive(rst, wce, w, rce, r);
        #1;
        check("shift_we", idx, shift_we, exp_we);
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input int idx, input logic fn, en, input logic [1:0] used,
                              input logic addr, err);
        check("if_full_n", idx, if_full_n, fn);
        check("if_empty_n", idx, if_empty_n, en);
        check("usedw", idx, usedw, used);
        check("shift_addr", idx, shift_addr, addr);
        check("err_flag", idx, err_flag, err);
    endtask

    initial begin
        //   rst wce w  rce r | we fn en used addr err
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);      // idle after reset
        add(0, 1, 1, 0, 0,  1, 1, 1, 1, 0, 0);          // push A
        add(0, 1, 1, 0, 0,  1, 0, 1, 2, 1, 0);          // push B -> full
        add(0, 0, 0, 1, 1,  0, 1, 1, 1, 0, 0);          // pop
        add(0, 0, 0, 1, 1,  0, 1, 0, 0, 0, 0);          // pop -> empty
        for (int i = 0; i < 3; i++)
            add(0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0);      // write masked by ce
        add(0, 1, 1, 0, 0,  1, 1, 1, 1, 0, 0);          // push
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, 0, 1,  0, 1, 1, 1, 0, 0);      // read masked by ce
        add(0, 1, 1, 1, 1,  1, 1, 1, 1, 0, 0);          // push+pop at usedw=1
        add(0, 0, 0, 1, 1,  0, 1, 0, 0, 0, 0);          // pop -> empty
        add(0, 1, 1, 1, 1,  1, 1, 1, 1, 0, E);          // read while empty, push lands
        add(0, 1, 1, 0, 0,  1, 0, 1, 2, 1, E);          // push -> full
        add(0, 1, 1, 0, 0,  0, 0, 1, 2, 1, E);          // write while full ignored
        add(0, 1, 1, 1, 1,  0, 1, 1, 1, 0, E);          // write full + read: pop only
        add(1, 0, 0, 1, 1,  0, 1, 0, 0, 0, 0);          // reset mid-operation

        din = 8'h00;
        drive(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_regs(-1, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].wce, vecs[i].w, vecs[i].rce, vecs[i].r, vecs[i].we, i);
            check_regs(i, vecs[i].fn, vecs[i].en, vecs[i].used, vecs[i].addr, vecs[i].err);
        end

        // Data order: A then B in, A then B out.
        din = 8'hA1; step(0, 1, 1, 0, 0, 1, 100);
        din = 8'hB2; step(0, 1, 1, 0, 0, 1, 101);
        check("dout", 102, dout, 8'hA1);
        step(0, 0, 0, 1, 1, 0, 103);
        check("dout", 104, dout, 8'hB2);
        step(0, 0, 0, 1, 1, 0, 105);
        check("if_empty_n", 106, if_empty_n, 0);

        // Simultaneous push+pop: the next value appears at slot 0.
        din = 8'hC3; step(0, 1, 1, 0, 0, 1, 110);
        check("dout", 111, dout, 8'hC3);
        din = 8'hD4; step(0, 1, 1, 1, 1, 1, 112);
        check("dout", 113, dout, 8'hD4);
        check_regs(114, 1, 1, 1, 0, 0);

        // Fill, overflow attempt, then reset with the handshakes still active.
        step(0, 1, 1, 0, 0, 1, 120);
        check_regs(121, 0, 1, 2, 1, 0);
        step(0, 1, 1, 0, 0, 0, 122);
        check_regs(123, 0, 1, 2, 1, E);
        step(1, 1, 1, 1, 1, 0, 124);
        check_regs(125, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 126);
        check_regs(127, 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel3_fifo_srl_ctrl.md
Name: kernel3_fifo_srl_ctrl

Overview:
Occupancy and handshake controller for the kernel3 shift-register FIFO storage (SRL array: on `we`, entries shift up by one and new data enters slot 0; `dout` is read from slot `addr`).
- Turns the producer write handshake and consumer read handshake into `shift_we` and `shift_addr`.
- Tracks fill level and generates `full_n`/`empty_n`.
- Sits between a kernel3 producer/consumer pair and one storage instance; holds no data itself.

Parameters:
ADDR_WIDTH, 1, width of `shift_addr`; must satisfy 2^ADDR_WIDTH >= DEPTH.
DEPTH, 2, storage entries; legal range 1..2^ADDR_WIDTH.

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
if_write_ce  in  1  producer clock enable
if_write  in  1  producer write request
if_full_n  out  1  1 = space available
if_read_ce  in  1  consumer clock enable
if_read  in  1  consumer read request
if_empty_n  out  1  1 = data valid at storage `dout`
shift_we  out  1  storage shift/write enable
shift_addr  out  ADDR_WIDTH  storage read slot (oldest entry)
usedw  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
err_flag  out  1  sticky protocol-error flag (see Optional Feature)

Behaviour:
- Clock and reset: single clock `clk`. Reset `reset` is synchronous and active-high and overrides all other inputs in that cycle.
- Reset values: `if_full_n`=1, `if_empty_n`=0, `shift_addr`=0, `usedw`=0, `err_flag`=0, state=EMPTY.
- Qualified events:
  - push = `if_write` & `if_write_ce` & `if_full_n`
  - pop = `if_read` & `if_read_ce` & `if_empty_n`
- `shift_we` = push. It is combinational, with no register stage, so data is captured in the same cycle as the handshake.
- All other outputs are registered and update on the edge following the event.
- States:
  - EMPTY: `usedw`=0
  - PARTIAL: 0 < `usedw` < DEPTH
  - FULL: `usedw`=DEPTH
  - `if_empty_n` = (state != EMPTY); `if_full_n` = (state != FULL); both are registered.
- Transitions:
  - push only: `usedw`+1. EMPTY goes to PARTIAL, or directly to FULL when DEPTH=1. PARTIAL goes to FULL when the new `usedw`=DEPTH.
  - pop only: `usedw`-1. FULL goes to PARTIAL, or directly to EMPTY when DEPTH=1. PARTIAL goes to EMPTY when the new `usedw`=0.
  - push and pop together: `usedw`, state and `shift_addr` are all unchanged. The shift moves the oldest entry up one slot while the pop retires it.
- `shift_addr` always equals `usedw`-1 when non-empty, and 0 when empty:
  - It increments on push-only unless leaving EMPTY (then stays 0).
  - It decrements on pop-only unless entering EMPTY (then stays 0).
  - It never wraps.
- Boundary conditions:
  - Write while FULL: ignored, no `shift_we`. Simultaneous pop in that cycle is still honoured.
  - Read while EMPTY: ignored; a simultaneous push still lands.
  - Any `_ce`=0 masks its request completely.
- Latency: a write is visible as `if_empty_n`=1 one cycle after the push. Storage `dout` is valid whenever `if_empty_n`=1.
- Reset mid-operation: contents are logically discarded; returns to EMPTY on the next edge regardless of the handshake inputs.

Optional Feature:
Macro: KERNEL3_FIFO_SRL_CTRL_ERR_EN.
- Defined:
  - `err_flag` is set on the cycle after `if_write`&`if_write_ce` while `if_full_n`=0 (overflow attempt).
  - It is also set after `if_read`&`if_read_ce` while `if_empty_n`=0 (underflow attempt).
  - Once set it stays set; only `reset` clears it.
- Undefined: `err_flag` is tied to constant 0 and no extra logic is generated. The port exists in both builds.

Test Plan:
1. Reset then idle (DEPTH=2): `if_full_n`=1, `if_empty_n`=0, `usedw`=0, `shift_addr`=0, `shift_we`=0 across 5 cycles.
2. Fill then drain (DEPTH=2):
   - Two pushes: `usedw` goes 1, then 2; `shift_addr` goes 0, then 1; `if_full_n`=0 after the 2nd.
   - Two pops: `usedw` goes 1, then 0; `shift_addr` goes 0, then 0; `if_empty_n`=0 after the 2nd.
   - Data order into the attached storage is A then B, and reads return A then B.
3. Simultaneous push+pop at `usedw`=1: `shift_we`=1; `usedw`, `shift_addr` and flags unchanged; the consumer sees the next value at slot 0 the following cycle.
4. Write while FULL with `if_read`=0: `shift_we`=0 and state unchanged. With `if_read`=1 in the same cycle, only the pop occurs: `usedw` goes 2 to 1.
5. `_ce` masking: `if_write`=1 with `if_write_ce`=0 for 3 cycles gives no `shift_we` and `usedw` stays 0. Same check for `if_read` with `if_read_ce`=0 at `usedw`=1.
6. Reset with `usedw`=2 and `err_flag`=1 (macro defined, after a write to FULL): next cycle shows all reset values. With the macro undefined, the same stimulus keeps `err_flag`=0 throughout.
